// File: rtl/mops_sdo_pkg.sv
// Shared constants, state encoding and frame packing for the MOPS-side SDO responder.
// Frames are 76 bits: 11-bit COB-ID, RTR bit, then eight data bytes with byte0 in the top bits.
package mops_sdo_pkg;

  localparam logic [7:0] SDO_CMD_UPLOAD_REQ = 8'h40;
  localparam logic [7:0] SDO_CMD_UPLOAD_RSP = 8'h43;
  localparam logic [7:0] SDO_CMD_DNLD4_REQ  = 8'h23;
  localparam logic [7:0] SDO_CMD_DNLD_RSP   = 8'h60;
  localparam logic [7:0] SDO_CMD_ABORT      = 8'h80;

  localparam logic [10:0] COB_RX_BASE = 11'h600;
  localparam logic [10:0] COB_TX_BASE = 11'h580;

  localparam logic [15:0] IDX_DEVICE_TYPE = 16'h1000;
  localparam logic [15:0] IDX_SCRATCH     = 16'h2001;
  localparam logic [15:0] IDX_ADC         = 16'h2400;

  localparam logic [31:0] ABORT_NO_OBJECT = 32'h06020000;
  localparam logic [31:0] ABORT_NO_SUB    = 32'h06090011;
  localparam logic [31:0] ABORT_TIMEOUT   = 32'h08000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ADC_WAIT,
    ST_BUILD,
    ST_SEND
  } sdo_state_t;

  // Index goes out little-endian in bytes 1..2 and the 32-bit payload little-endian in bytes 4..7.
  function automatic logic [75:0] build_sdo_frame(input logic [10:0] cob,
                                                  input logic [7:0]  cmd,
                                                  input logic [15:0] idx,
                                                  input logic [7:0]  sub,
                                                  input logic [31:0] data32);
    return {cob, 1'b0, cmd, idx[7:0], idx[15:8], sub,
            data32[7:0], data32[15:8], data32[23:16], data32[31:24]};
  endfunction

endpackage

// File: rtl/mops_sdo_responder.sv
// CANopen SDO responder: answers expedited uploads of ADC channels, device type and a scratch
// register, accepts 4-byte downloads to scratch, and returns one response frame per request.
import mops_sdo_pkg::*;

module mops_sdo_responder #(
  parameter logic [4:0]  n_adc_ch    = 5'd16,
  parameter logic [15:0] adc_timeout = 16'd1000,
  parameter logic [31:0] device_type = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  node_id,
  input  logic        rx_valid,
  input  logic [75:0] rx_frame,
  output logic        busy,
  output logic        adc_req,
  output logic [4:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [15:0] adc_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [75:0] tx_frame,
  output logic [7:0]  drop_cnt
);

  sdo_state_t  state, state_next;
  logic [63:0] req_payload;
  logic [7:0]  resp_cmd;
  logic [31:0] resp_data;
  logic [31:0] scratch;
  logic [15:0] timer;

  logic [7:0]  dec_cmd;
  logic [31:0] dec_data;
  logic        dec_scratch_wr;

  logic [10:0] rx_cob_own, tx_cob_own;
  logic        rx_match;
  logic [7:0]  req_cmd, req_sub;
  logic [15:0] req_idx;
  logic [31:0] dl_data;
  logic        sub_in_adc_range;
  logic [16:0] timer_inc;
  logic        timeout_hit;

  assign rx_cob_own = COB_RX_BASE + {4'b0, node_id};
  assign tx_cob_own = COB_TX_BASE + {4'b0, node_id};
  assign rx_match   = rx_valid && (rx_frame[75:65] == rx_cob_own) && !rx_frame[64];

  assign req_cmd = req_payload[63:56];
  assign req_idx = {req_payload[47:40], req_payload[55:48]};
  assign req_sub = req_payload[39:32];
  assign dl_data = {req_payload[7:0], req_payload[15:8], req_payload[23:16], req_payload[31:24]};

  assign sub_in_adc_range = (req_sub != 8'd0) && (req_sub <= {3'b0, n_adc_ch});
  assign timer_inc        = {1'b0, timer} + 17'd1;
  assign timeout_hit      = timer_inc >= {1'b0, adc_timeout};

  assign busy     = (state != ST_IDLE);
  assign adc_req  = (state == ST_ADC_WAIT);
  assign tx_valid = (state == ST_SEND);

  // Decode defaults to "no such object" so every unlisted request falls through to an abort.
  always_comb begin
    state_next     = state;
    dec_cmd        = SDO_CMD_ABORT;
    dec_data       = ABORT_NO_OBJECT;
    dec_scratch_wr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_match) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        state_next = ST_BUILD;
        if (req_cmd == SDO_CMD_UPLOAD_REQ && req_idx == IDX_ADC) begin
          if (sub_in_adc_range) state_next = ST_ADC_WAIT;
          else                  dec_data   = ABORT_NO_SUB;
        end else if (req_cmd == SDO_CMD_UPLOAD_REQ && req_idx == IDX_DEVICE_TYPE && req_sub == 8'd0) begin
          dec_cmd  = SDO_CMD_UPLOAD_RSP;
          dec_data = device_type;
        end else if (req_cmd == SDO_CMD_UPLOAD_REQ && req_idx == IDX_SCRATCH && req_sub == 8'd0) begin
          dec_cmd  = SDO_CMD_UPLOAD_RSP;
          dec_data = scratch;
        end else if (req_cmd == SDO_CMD_DNLD4_REQ && req_idx == IDX_SCRATCH && req_sub == 8'd0) begin
          dec_cmd        = SDO_CMD_DNLD_RSP;
          dec_data       = 32'h0;
          dec_scratch_wr = 1'b1;
        end
      end
      ST_ADC_WAIT: begin
        if (adc_ack || timeout_hit) state_next = ST_BUILD;
      end
      ST_BUILD: state_next = ST_SEND;
      ST_SEND: begin
        if (tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Request bytes are captured once at acceptance and echoed back untouched in the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_payload <= 64'h0;
      adc_ch      <= 5'd0;
      scratch     <= 32'h0;
    end else begin
      if (state == ST_IDLE && rx_match) req_payload <= rx_frame[63:0];
      if (state == ST_DECODE && state_next == ST_ADC_WAIT) adc_ch <= req_sub[4:0] - 5'd1;
      if (state == ST_DECODE && dec_scratch_wr) scratch <= dl_data;
    end
  end

  // An ack wins over a timeout that expires in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_cmd  <= 8'h0;
      resp_data <= 32'h0;
      timer     <= 16'h0;
    end else begin
      timer <= (state == ST_ADC_WAIT) ? timer_inc[15:0] : 16'h0;
      if (state == ST_DECODE) begin
        resp_cmd  <= dec_cmd;
        resp_data <= dec_data;
      end else if (state == ST_ADC_WAIT) begin
        if (adc_ack) begin
          resp_cmd  <= SDO_CMD_UPLOAD_RSP;
          resp_data <= {16'h0, adc_data};
        end else if (timeout_hit) begin
          resp_cmd  <= SDO_CMD_ABORT;
          resp_data <= ABORT_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_frame <= 76'h0;
      drop_cnt <= 8'h0;
    end else begin
      if (state == ST_BUILD)
        tx_frame <= build_sdo_frame(tx_cob_own, resp_cmd, req_idx, req_sub, resp_data);
      if (rx_match && state != ST_IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
